// File: rtl/elastic_fifo_buffer.sv
// elastic_fifo_buffer: DEPTH-entry valid/ready elastic buffer with occupancy, almost-full and flush.
// Optional macro ELASTIC_FIFO_BYPASS_EN: zero-latency pass-through when the buffer is empty.
module elastic_fifo_buffer #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [WIDTH-1:0]             data_in,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [WIDTH-1:0]             data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  generate
    if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_params
      $error("elastic_fifo_buffer: DEPTH must be >= 2 and AF_THRESH within 1..DEPTH");
    end
  endgenerate
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             empty, bypass, wr, rd;
  assign empty       = count == '0;
  // ready_in looks only at registered occupancy, so a full buffer never accepts even if it pops.
  assign ready_in    = count != CW'(DEPTH);
  assign almost_full = count >= CW'(AF_THRESH);
`ifdef ELASTIC_FIFO_BYPASS_EN
  assign bypass      = empty & valid_in & ready_out;
  assign valid_out   = !empty | valid_in;
  assign data_out    = empty ? data_in : mem[rd_ptr];
`else
  assign bypass      = 1'b0;
  assign valid_out   = !empty;
  assign data_out    = mem[rd_ptr];
`endif
  assign wr = valid_in & ready_in & ~bypass & ~flush;
  assign rd = !empty & ready_out;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= nxt(wr_ptr);
      if (rd) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(wr) - CW'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= data_in;
endmodule

// File: tb/tb_elastic_fifo_buffer.sv
// tb_elastic_fifo_buffer: directed vectors and scoreboard checks for elastic_fifo_buffer (default build).
module tb_elastic_fifo_buffer;
  logic        clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic        valid_in = 1'b0, ready_out = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_out, ready_in, almost_full;
  logic [31:0] data_out;
  logic [2:0]  count;
  logic        v3 = 1'b0, ro3 = 1'b0, vo3, ri3, af3;
  logic [31:0] d3 = '0, do3;
  logic [1:0]  c3;
  int          total = 0, bad = 0;
  elastic_fifo_buffer #(.WIDTH(32), .DEPTH(4), .AF_THRESH(3)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .count(count), .almost_full(almost_full));
  elastic_fifo_buffer #(.WIDTH(32), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .flush(1'b0), .valid_in(v3), .ready_in(ri3),
    .data_in(d3), .valid_out(vo3), .ready_out(ro3), .data_out(do3),
    .count(c3), .almost_full(af3));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  typedef struct {
    logic vin, rdy, fl;
    logic [31:0] d;
    logic vout, rin, af;
    logic [2:0] cnt;
    logic chkd;
    logic [31:0] dout;
  } vec_t;
  vec_t vt[22];
  function automatic vec_t mk(input logic vin, rdy, fl, input logic [31:0] d, input logic vout, rin, af,
                              input logic [2:0] cnt, input logic chkd, input logic [31:0] dout);
    vec_t r;
    r.vin = vin; r.rdy = rdy; r.fl = fl; r.d = d; r.vout = vout; r.rin = rin; r.af = af;
    r.cnt = cnt; r.chkd = chkd; r.dout = dout;
    return r;
  endfunction
  logic [31:0] q[$];
  logic [31:0] e, prev_d;
  logic        prev_stall;
  int          sent, rcv, pushed, popped;
  initial begin
    // fill/stall, full-simultaneous, flush and flush-with-pop sequences (DEPTH=4, AF_THRESH=3)
    vt[0]  = mk(1, 0, 0, 32'h0100, 0, 1, 0, 0, 0, 0);
    vt[1]  = mk(1, 0, 0, 32'h0101, 1, 1, 0, 1, 1, 32'h0100);
    vt[2]  = mk(1, 0, 0, 32'h0102, 1, 1, 0, 2, 1, 32'h0100);
    vt[3]  = mk(1, 0, 0, 32'h0103, 1, 1, 1, 3, 1, 32'h0100);
    vt[4]  = mk(1, 0, 0, 32'h0104, 1, 0, 1, 4, 1, 32'h0100);
    vt[5]  = mk(1, 1, 0, 32'h0104, 1, 0, 1, 4, 1, 32'h0100);
    vt[6]  = mk(1, 1, 0, 32'h0104, 1, 1, 1, 3, 1, 32'h0101);
    vt[7]  = mk(0, 1, 0, 32'h0000, 1, 1, 1, 3, 1, 32'h0102);
    vt[8]  = mk(0, 1, 0, 32'h0000, 1, 1, 0, 2, 1, 32'h0103);
    vt[9]  = mk(0, 1, 0, 32'h0000, 1, 1, 0, 1, 1, 32'h0104);
    vt[10] = mk(0, 0, 0, 32'h0000, 0, 1, 0, 0, 0, 0);
    vt[11] = mk(1, 0, 0, 32'h0300, 0, 1, 0, 0, 0, 0);
    vt[12] = mk(1, 0, 0, 32'h0301, 1, 1, 0, 1, 1, 32'h0300);
    vt[13] = mk(1, 0, 0, 32'h0302, 1, 1, 0, 2, 1, 32'h0300);
    vt[14] = mk(1, 0, 1, 32'h0303, 1, 1, 1, 3, 1, 32'h0300);
    vt[15] = mk(0, 1, 0, 32'h0000, 0, 1, 0, 0, 0, 0);
    vt[16] = mk(1, 1, 0, 32'h0400, 0, 1, 0, 0, 0, 0);
    vt[17] = mk(0, 1, 0, 32'h0000, 1, 1, 0, 1, 1, 32'h0400);
    vt[18] = mk(0, 0, 0, 32'h0000, 0, 1, 0, 0, 0, 0);
    vt[19] = mk(1, 0, 0, 32'h0500, 0, 1, 0, 0, 0, 0);
    vt[20] = mk(1, 1, 1, 32'h0501, 1, 1, 0, 1, 1, 32'h0500);
    vt[21] = mk(0, 0, 0, 32'h0000, 0, 1, 0, 0, 0, 0);
    valid_in = 1'b1;
    data_in  = 32'hdead;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_vout", valid_out, 0);
      chk("rst_rin", ready_in, 1);
      chk("rst_cnt", count, 0);
      chk("rst_af", almost_full, 0);
    end
    reset = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      valid_in  = k < 8;
      data_in   = k;
      ready_out = 1'b1;
      #1;
      chk("stream_vout", valid_out, k != 0);
      chk("stream_cnt", count, k != 0);
      if (k != 0) chk("stream_data", data_out, k - 1);
      @(negedge clk);
    end
    for (int i = 0; i < 22; i++) begin
      valid_in = vt[i].vin; ready_out = vt[i].rdy; flush = vt[i].fl; data_in = vt[i].d;
      #1;
      chk($sformatf("vec%0d_vout", i), valid_out, vt[i].vout);
      chk($sformatf("vec%0d_rin", i), ready_in, vt[i].rin);
      chk($sformatf("vec%0d_cnt", i), count, vt[i].cnt);
      chk($sformatf("vec%0d_af", i), almost_full, vt[i].af);
      if (vt[i].chkd) chk($sformatf("vec%0d_dout", i), data_out, vt[i].dout);
      @(negedge clk);
    end
    flush = 1'b0;
    valid_in = 1'b1; ready_out = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_cnt", count, 0);
    chk("async_rst_vout", valid_out, 0);
    chk("async_rst_rin", ready_in, 1);
    @(negedge clk);
    reset = 1'b1; valid_in = 1'b0;
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 200 && rcv < 16; cyc++) begin
      v3 = sent < 16; d3 = 32'h0200 + sent; ro3 = (cyc % 2) == 0;
      #1;
      if (vo3 && ro3) begin
        chk("wrap_data", do3, 32'h0200 + rcv);
        rcv++;
      end
      if (v3 && ri3) sent++;
      @(negedge clk);
    end
    v3 = 1'b0; ro3 = 1'b0;
    #1;
    chk("wrap_total", rcv, 16);
    chk("wrap_cnt", c3, 0);
    prev_stall = 1'b0; prev_d = '0; pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 520; cyc++) begin
      valid_in  = cyc < 500 ? $urandom_range(0, 99) < 70 : 1'b0;
      ready_out = cyc < 500 ? 1'($urandom_range(0, 1)) : 1'b1;
      data_in   = $urandom;
      #1;
      chk("sb_cnt", count, q.size());
      chk("sb_rin", ready_in, q.size() != 4);
      if (prev_stall) begin
        chk("sb_hold_v", valid_out, 1);
        chk("sb_hold_d", data_out, prev_d);
      end
      if (valid_out && ready_out) begin
        e = q.size() > 0 ? q.pop_front() : 32'hx;
        chk("sb_data", data_out, e);
        popped++;
      end
      if (valid_in && ready_in) begin
        q.push_back(data_in);
        pushed++;
      end
      prev_stall = valid_out & ~ready_out;
      prev_d = data_out;
      @(negedge clk);
    end
    chk("sb_leftover", q.size(), 0);
    chk("sb_balance", popped, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
